// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage 19-bit CPU.
// Forwarding-select encodings and the hazard shadow-entry record.
package cpu_pkg;

  localparam int REG_W_DEF = 3;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [REG_W_DEF-1:0] rd;
    logic                 is_load;
    logic [REG_W_DEF-1:0] rs;
    logic [REG_W_DEF-1:0] rt;
    logic                 use_rs;
    logic                 use_rt;
  } sh_entry_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding source select for the EX-stage ALU input mux.
// The nearest non-load producer wins; loads in MEM are never a source.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src,
  input  sh_entry_t        mem,
  input  sh_entry_t        wb,
  output logic [1:0]       sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem.valid && mem.reg_write &&
                   !mem.is_load && (mem.rd == src);
  assign wb_hit  = wb.valid && wb.reg_write &&
                   (wb.rd == src) && !mem_hit;

  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      mem_hit: sel = FWD_EXMEM;
      wb_hit:  sel = FWD_MEMWB;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and freeze control plus operand forwarding selects.
// Keeps a shadow of EX/MEM/WB control state and two event counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reg_write,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  sh_entry_t  sh_ex;
  sh_entry_t  sh_mem;
  sh_entry_t  sh_wb;
  sh_entry_t  id_ent;
  logic       hazard;
  logic       live;
  logic       redirect;
  logic       load_use;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign id_ent = '{
    valid:     id_valid,
    reg_write: id_reg_write,
    rd:        id_rd,
    is_load:   id_is_load,
    rs:        id_rs,
    rt:        id_rt,
    use_rs:    id_use_rs,
    use_rt:    id_use_rt
  };

  assign hazard = sh_ex.valid && sh_ex.is_load && id_valid &&
                  ((id_use_rs && id_rs == sh_ex.rd) ||
                   (id_use_rt && id_rt == sh_ex.rd));

  // Reset outranks the freeze, the freeze outranks everything else.
  assign live     = !reset && !mem_busy;
  assign redirect = live && ex_redirect;
  assign load_use = live && !ex_redirect && hazard;

  assign freeze_all  = !reset && mem_busy;
  assign flush_if_id = redirect;
  assign stall_if_id = load_use;
  assign bubble_ex   = redirect || load_use;

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src (sh_ex.rs),
    .mem (sh_mem),
    .wb  (sh_wb),
    .sel (sel_a)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src (sh_ex.rt),
    .mem (sh_mem),
    .wb  (sh_wb),
    .sel (sel_b)
  );

  assign fwd_a = reset ? FWD_RF : sel_a;
  assign fwd_b = reset ? FWD_RF : sel_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_ex       <= '0;
      sh_mem      <= '0;
      sh_wb       <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!mem_busy) begin
      sh_wb  <= sh_mem;
      sh_mem <= sh_ex;
      sh_ex  <= bubble_ex ? '0 : id_ent;
      if (load_use && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (redirect && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an expected-value queue.
// Counters are narrowed to 4 bits so saturation is reachable.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic [2:0] rd;
    logic       ld;
  } id_t;

  typedef struct packed {
    logic       st;
    logic       bu;
    logic       fl;
    logic       fr;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_reg_write;
  logic [2:0] id_rd;
  logic       id_is_load;
  logic       ex_redirect;
  logic       mem_busy;
  logic       stall_if_id;
  logic       bubble_ex;
  logic       flush_if_id;
  logic       freeze_all;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [3:0] stall_count;
  logic [3:0] flush_count;

  int   total = 0;
  int   bad   = 0;
  int   stepn = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(4), .REG_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_reg_write (id_reg_write),
    .id_rd        (id_rd),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .flush_if_id  (flush_if_id),
    .freeze_all   (freeze_all),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  function automatic id_t ins(
    logic v, logic [2:0] rs, logic [2:0] rt,
    logic urs, logic urt, logic rw,
    logic [2:0] rd, logic ld);
    ins = '{v, rs, rt, urs, urt, rw, rd, ld};
  endfunction

  function automatic exp_t ex(
    logic st, logic bu, logic fl, logic fr,
    logic [1:0] fa, logic [1:0] fb,
    logic [3:0] sc, logic [3:0] fc);
    ex = '{st, bu, fl, fr, fa, fb, sc, fc};
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exv);
    total++;
    assert (obs === exv) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h",
             tag, stepn, obs, exv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL queue step=%0d observed=empty expected=entry", stepn);
      return;
    end
    total--;
    e = sb.pop_front();
    chk("stall",  {3'b0, stall_if_id}, {3'b0, e.st});
    chk("bubble", {3'b0, bubble_ex},   {3'b0, e.bu});
    chk("flush",  {3'b0, flush_if_id}, {3'b0, e.fl});
    chk("freeze", {3'b0, freeze_all},  {3'b0, e.fr});
    chk("fwd_a",  {2'b0, fwd_a},       {2'b0, e.fa});
    chk("fwd_b",  {2'b0, fwd_b},       {2'b0, e.fb});
    chk("stall_count", stall_count, e.sc);
    chk("flush_count", flush_count, e.fc);
  endtask

  task automatic step(input id_t i, input logic redir,
                      input logic busy, input logic rst,
                      input exp_t e);
    stepn++;
    id_valid     = i.v;
    id_rs        = i.rs;
    id_rt        = i.rt;
    id_use_rs    = i.urs;
    id_use_rt    = i.urt;
    id_reg_write = i.rw;
    id_rd        = i.rd;
    id_is_load   = i.ld;
    ex_redirect  = redir;
    mem_busy     = busy;
    reset        = rst;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    id_t nop;
    id_t ldm3;
    id_t add3;
    id_t ldm3nw;
    logic [3:0] sc;
    nop    = '0;
    ldm3   = ins(1, 3'd5, 3'd0, 1, 0, 1, 3'd3, 1);
    add3   = ins(1, 3'd3, 3'd1, 1, 1, 1, 3'd4, 0);
    ldm3nw = ins(1, 3'd5, 3'd0, 1, 0, 0, 3'd3, 1);

    reset = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0;
    id_use_rt = 0; id_reg_write = 0; id_rd = 0; id_is_load = 0;
    ex_redirect = 0; mem_busy = 0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset holding with mem_busy and redirect also high
    step(nop, 1, 1, 1, ex(0,0,0,0,0,0,0,0));

    // load-use: LDM r3 then ADD reading r3
    step(ldm3, 0, 0, 0, ex(0,0,0,0,0,0,0,0));
    step(add3, 0, 0, 0, ex(1,1,0,0,0,0,0,0));
    step(add3, 0, 0, 0, ex(0,0,0,0,0,0,1,0));
    step(nop,  0, 0, 0, ex(0,0,0,0,2'b10,0,1,0));

    // forwarding distance and nearest-producer priority
    step(ins(1,3'd6,3'd7,1,1,1,3'd2,0), 0,0,0, ex(0,0,0,0,0,0,1,0));
    step(ins(1,3'd1,3'd2,1,1,1,3'd5,0), 0,0,0, ex(0,0,0,0,0,0,1,0));
    step(ins(1,3'd6,3'd7,1,1,1,3'd2,0), 0,0,0, ex(0,0,0,0,0,2'b01,1,0));
    step(ins(1,3'd1,3'd2,1,1,1,3'd2,0), 0,0,0, ex(0,0,0,0,0,0,1,0));
    step(ins(1,3'd3,3'd2,1,1,1,3'd6,0), 0,0,0, ex(0,0,0,0,0,2'b01,1,0));
    step(ins(1,3'd3,3'd2,1,1,1,3'd7,0), 0,0,0, ex(0,0,0,0,0,2'b01,1,0));
    step(nop, 0, 0, 0, ex(0,0,0,0,0,2'b10,1,0));

    // redirect beats a simultaneous load-use
    step(ins(1,3'd5,3'd0,1,0,1,3'd1,1), 0,0,0, ex(0,0,0,0,0,0,1,0));
    step(ins(1,3'd1,3'd0,1,0,1,3'd4,0), 1,0,0, ex(0,1,1,0,0,0,1,0));
    step(nop, 0, 0, 0, ex(0,0,0,0,0,0,1,1));

    // freeze for 3 cycles over a pending load-use
    step(ldm3, 0, 0, 0, ex(0,0,0,0,0,0,1,1));
    step(add3, 1, 1, 0, ex(0,0,0,1,0,0,1,1));
    step(add3, 0, 1, 0, ex(0,0,0,1,0,0,1,1));
    step(add3, 0, 1, 0, ex(0,0,0,1,0,0,1,1));
    step(add3, 0, 0, 0, ex(1,1,0,0,0,0,1,1));
    step(add3, 0, 0, 0, ex(0,0,0,0,0,0,2,1));
    step(nop,  0, 0, 0, ex(0,0,0,0,2'b10,0,2,1));

    // 20 more load-use stalls; the counter stops at 15
    for (int i = 0; i < 20; i++) begin
      sc = (i + 2 > 15) ? 4'd15 : 4'(i + 2);
      step(ldm3nw, 0, 0, 0, ex(0,0,0,0,0,0,sc,1));
      step(add3,   0, 0, 0, ex(1,1,0,0,0,0,sc,1));
    end
    step(nop, 0, 0, 0, ex(0,0,0,0,0,0,15,1));

    // reset while frozen with forwarding active
    step(ins(1,3'd6,3'd0,1,0,1,3'd2,0), 0,0,0, ex(0,0,0,0,0,0,15,1));
    step(ins(1,3'd2,3'd2,1,1,1,3'd5,0), 0,0,0, ex(0,0,0,0,0,0,15,1));
    step(nop, 0, 1, 0, ex(0,0,0,1,2'b01,2'b01,15,1));
    step(nop, 1, 1, 1, ex(0,0,0,0,0,0,15,1));
    step(nop, 0, 0, 0, ex(0,0,0,0,0,0,0,0));
    step(nop, 1, 0, 0, ex(0,1,1,0,0,0,0,0));
    step(nop, 0, 0, 0, ex(0,0,0,0,0,0,0,1));

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
